p2s_tx: RTL and testbench
=========================

P2S_TX -- requirements
Module: p2s_tx

Interface
REQ-001 The block SHALL have parameter: width, 8, number of data bits per word; legal range 2..32.
REQ-002 The block SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 The block SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL have port: parin  input  width  parallel word to transmit.
REQ-005 The block SHALL have port: start  input  1  request to transmit parin; qualified by ready.
REQ-006 The block SHALL have port: ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL have port: serout  output  1  serial data, MSB first.
REQ-008 The block SHALL have port: load  output  1  frame strobe, high exactly while serout carries a valid bit; drives the load input of the s2p receiver directly.
REQ-009 The block SHALL have port: done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-010 The block SHALL implement FSM states IDLE, SHIFT and GAP, with all outputs registered.
REQ-011 The block SHALL accept a word only on a rising edge where start=1 and ready=1, and SHALL ignore start when ready=0, with no side effect.
REQ-012 On acceptance in IDLE, the block SHALL capture parin into the shift register, clear the bit counter and enter SHIFT.
REQ-013 If acceptance is at edge N, then serout SHALL equal parin[width-1-k] and load SHALL be 1 in cycle N+1+k, for k=0..width-1.
REQ-014 In SHIFT, the block SHALL shift left one bit per cycle, and when the counter reaches width-1 the next state SHALL be GAP.
REQ-015 GAP SHALL last exactly one cycle (cycle N+width+1), with load=0, serout=0 and done=1; this gap lets s2p transfer its buffer to parout.
REQ-016 After GAP the block SHALL enter IDLE, or SHIFT per REQ-023.
REQ-017 The block SHALL hold done=0 in all cycles other than GAP.
REQ-018 The block SHALL drive load=0 and serout=0 in IDLE.
REQ-019 In the base configuration, ready SHALL be 1 only in IDLE, so the minimum word period is width+2 cycles.
REQ-020 The bit counter SHALL be $clog2(width) bits wide and SHALL never wrap inside a word.
REQ-021 Back-to-back words SHALL always be separated by at least one load=0 cycle.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL enter IDLE and set serout=0, load=0, done=0 and ready=1, clear the counter and shift register, and discard any held word. This applies mid-frame too; a partial word is dropped, not completed. rst SHALL take priority over a simultaneous start.

Configuration
REQ-023 With macro P2S_TX_DOUBLE_BUF_EN defined, the block SHALL add a one-word holding register plus a valid flag, with the following behaviour:
- ready = !hold_valid in every state.
- start accepted in SHIFT captures parin into hold and sets hold_valid.
- start accepted in GAP, or hold_valid=1 in GAP: the next state is SHIFT with the held or new word; the gap stays exactly one cycle and hold_valid clears.
- Acceptance in IDLE behaves per REQ-012.
- Minimum word period: width+1 cycles.
REQ-024 Without P2S_TX_DOUBLE_BUF_EN, the block SHALL contain no holding register and SHALL behave per REQ-019.

Verification
REQ-025 The bench SHALL cover this scenario (width=8): parin=8'hA5 with start at edge 0 -> serout 1,0,1,0,0,1,0,1 in cycles 1..8 with load=1; done=1 and load=0 in cycle 9; ready=1 in cycle 10.
REQ-026 The bench SHALL cover this scenario: loopback into s2p (width=8, shared clk/rst) sending 8'hA5 then 8'h3C -> s2p parout reads 8'hA5 after the first gap and 8'h3C after the second.
REQ-027 The bench SHALL cover this scenario (base configuration): start with parin=8'hFF in cycle 4 of an 8'h00 word -> ignored; the 8'h00 frame completes unchanged and no second frame occurs.
REQ-028 The bench SHALL cover this scenario: rst=1 in cycle 3 of word 8'hF0 -> next cycle has load=0, serout=0, done=0, ready=1; a following start with 8'h81 transmits 1,0,0,0,0,0,0,1.
REQ-029 The bench SHALL cover this scenario: rst=1 and start=1 on the same edge -> no frame starts and ready=1 next cycle.
REQ-030 The bench SHALL cover this scenario (P2S_TX_DOUBLE_BUF_EN): 8'h3C accepted at edge 0 and 8'hC3 at edge 2 -> ready=0 from cycle 3 until the gap; 8'h3C in cycles 1..8, gap in cycle 9, 8'hC3 in cycles 10..17, gap in cycle 18.

Source files
------------

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: MSB-first frames qualified by load, with a one-cycle gap strobe.
// Optional one-word holding register enabled by defining P2S_TX_DOUBLE_BUF_EN.
module p2s_tx #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] parin,
  input  logic             start,
  output logic             ready,
  output logic             serout,
  output logic             load,
  output logic             done
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [width-1:0] r_shift;
  logic [width-1:0] w_shiftNext;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cntNext;
  logic             r_serout;
  logic             r_load;
  logic             r_done;
  logic             r_ready;
  logic             w_seroutNext;
  logic             w_loadNext;
  logic             w_doneNext;
  logic             w_readyNext;
  logic             w_accept;
`ifdef P2S_TX_DOUBLE_BUF_EN
  logic [width-1:0] r_hold;
  logic [width-1:0] w_holdNext;
  logic             r_holdValid;
  logic             w_holdValidNext;
`endif

  assign w_accept = start & r_ready;

  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_cntNext   = r_cnt;
`ifdef P2S_TX_DOUBLE_BUF_EN
    w_holdNext      = r_hold;
    w_holdValidNext = r_holdValid;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shiftNext = parin;
          w_cntNext   = '0;
          w_stateNext = SHIFT;
        end
      end
      SHIFT: begin
        w_shiftNext = r_shift << 1;
        if (r_cnt == LAST) begin
          w_stateNext = GAP;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
`ifdef P2S_TX_DOUBLE_BUF_EN
        if (w_accept) begin
          w_holdNext      = parin;
          w_holdValidNext = 1'b1;
        end
`endif
      end
      GAP: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
`ifdef P2S_TX_DOUBLE_BUF_EN
        // A held word has priority; ready is low while one is held, so no new accept can collide.
        if (r_holdValid) begin
          w_shiftNext     = r_hold;
          w_holdValidNext = 1'b0;
          w_stateNext     = SHIFT;
        end else if (w_accept) begin
          w_shiftNext = parin;
          w_stateNext = SHIFT;
        end
`endif
      end
      default: begin
        w_stateNext = IDLE;
        w_shiftNext = '0;
        w_cntNext   = '0;
      end
    endcase

    // Outputs are precomputed from the next state so they can be registered.
    w_loadNext   = (w_stateNext == SHIFT);
    w_seroutNext = (w_stateNext == SHIFT) & w_shiftNext[width-1];
    w_doneNext   = (w_stateNext == GAP);
`ifdef P2S_TX_DOUBLE_BUF_EN
    w_readyNext  = ~w_holdValidNext;
`else
    w_readyNext  = (w_stateNext == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_serout <= 1'b0;
      r_load   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
`ifdef P2S_TX_DOUBLE_BUF_EN
      r_hold      <= '0;
      r_holdValid <= 1'b0;
`endif
    end else begin
      r_state  <= w_stateNext;
      r_shift  <= w_shiftNext;
      r_cnt    <= w_cntNext;
      r_serout <= w_seroutNext;
      r_load   <= w_loadNext;
      r_done   <= w_doneNext;
      r_ready  <= w_readyNext;
`ifdef P2S_TX_DOUBLE_BUF_EN
      r_hold      <= w_holdNext;
      r_holdValid <= w_holdValidNext;
`endif
    end
  end

  assign ready  = r_ready;
  assign serout = r_serout;
  assign load   = r_load;
  assign done   = r_done;

endmodule

// File: tb/tb_p2s_tx.sv
// Self-checking bench for p2s_tx: directed vector table, hand-written corner sequences,
// and a randomized phase checked against a slot-queue reference model.
module tb_p2s_tx;

  localparam int WIDTH = 8;

`ifdef P2S_TX_DOUBLE_BUF_EN
  localparam logic BUSY_READY = 1'b1;
`else
  localparam logic BUSY_READY = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] parin;
  logic             start;
  logic             ready;
  logic             serout;
  logic             load;
  logic             done;

  int vectors;
  int miscompares;

  p2s_tx #(.width(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .parin  (parin),
    .start  (start),
    .ready  (ready),
    .serout (serout),
    .load   (load),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural s2p receiver used for the loopback check.
  logic [WIDTH-1:0] s2pBuf;
  logic [WIDTH-1:0] s2pParout;
  logic             s2pPrevLoad;

  always @(posedge clk) begin
    if (rst) begin
      s2pBuf      <= '0;
      s2pParout   <= '0;
      s2pPrevLoad <= 1'b0;
    end else begin
      s2pPrevLoad <= load;
      if (load) s2pBuf <= {s2pBuf[WIDTH-2:0], serout};
      else if (s2pPrevLoad) s2pParout <= s2pBuf;
    end
  end

  typedef struct {
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] parin;
    logic             expLoad;
    logic             expSerout;
    logic             expDone;
    logic             expReady;
  } vec_t;

  typedef struct packed {
    logic ld;
    logic so;
    logic dn;
  } slot_t;

  vec_t  tbl[10];
  slot_t modelQ[$];

  task automatic applyStimulus(input logic r, input logic s, input logic [WIDTH-1:0] p);
    rst   = r;
    start = s;
    parin = p;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input logic eLoad, input logic eSer, input logic eDone, input logic eReady);
    checkOutput({name, ".load"},   32'(load),   32'(eLoad));
    checkOutput({name, ".serout"}, 32'(serout), 32'(eSer));
    checkOutput({name, ".done"},   32'(done),   32'(eDone));
    checkOutput({name, ".ready"},  32'(ready),  32'(eReady));
  endtask

  task automatic checkFrame(input string name, input logic [WIDTH-1:0] word);
    logic [WIDTH-1:0] w;
    w = word;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      checkOutput({name, ".load"},   32'(load),   32'd1);
      checkOutput({name, ".serout"}, 32'(serout), 32'(w[k]));
      checkOutput({name, ".done"},   32'(done),   32'd0);
      applyStimulus(1'b0, 1'b0, '0);
    end
    checkAll({name, ".gap"}, 1'b0, 1'b0, 1'b1, BUSY_READY);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      applyStimulus(1'b0, 1'b0, '0);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s: done not seen, got %b expected 1", name, done);
    end
  endtask

  initial begin
    logic             r;
    logic             s;
    logic [WIDTH-1:0] p;
    logic             mReady;
    slot_t            cur;

    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    parin = '0;

    // A5 frame: bits 1,0,1,0,0,1,0,1 then gap, then idle
    tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, BUSY_READY};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, BUSY_READY};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, BUSY_READY};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, BUSY_READY};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, BUSY_READY};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, BUSY_READY};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, BUSY_READY};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, BUSY_READY};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, BUSY_READY};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].start, tbl[i].parin);
      checkAll($sformatf("tblA5[%0d]", i), tbl[i].expLoad, tbl[i].expSerout, tbl[i].expDone, tbl[i].expReady);
    end

    // Loopback into behavioural s2p
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    waitDone("loop1.done");
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("loop1.parout", 32'(s2pParout), 32'h000000A5);
    checkOutput("loop1.ready", 32'(ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    waitDone("loop2.done");
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("loop2.parout", 32'(s2pParout), 32'h0000003C);

`ifndef P2S_TX_DOUBLE_BUF_EN
    // Start while busy is ignored
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      checkOutput($sformatf("busy.c%0d.serout", c), 32'(serout), 32'd0);
      checkOutput($sformatf("busy.c%0d.load", c), 32'(load), (c <= 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("busy.c%0d.done", c), 32'(done), (c == 9) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, (c == 4), (c == 4) ? 8'hFF : 8'h00);
    end
`endif

    // Reset mid-frame drops the word
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'hF0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("midrst.pre.serout", 32'(serout), 32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    checkAll("midrst.post", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h81);
    checkFrame("after81", 8'h81);
    applyStimulus(1'b0, 1'b0, '0);

    // Reset beats a simultaneous start
    applyStimulus(1'b1, 1'b1, 8'h55);
    checkAll("rststart", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, '0);
      checkAll($sformatf("rststart.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1);
    end

`ifdef P2S_TX_DOUBLE_BUF_EN
    // Two words back to back through the holding register
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    checkOutput("dbuf.c1.ready", 32'(ready), 32'd1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("dbuf.c2.ready", 32'(ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hC3);
    begin
      logic [WIDTH-1:0] wa;
      logic [WIDTH-1:0] wb;
      wa = 8'h3C;
      wb = 8'hC3;
      for (int c = 3; c <= 19; c++) begin
        if (c <= 8)
          checkAll($sformatf("dbuf.c%0d", c), 1'b1, wa[8-c], 1'b0, 1'b0);
        else if (c == 9)
          checkAll("dbuf.c9", 1'b0, 1'b0, 1'b1, 1'b0);
        else if (c <= 17)
          checkAll($sformatf("dbuf.c%0d", c), 1'b1, wb[17-c], 1'b0, 1'b1);
        else if (c == 18)
          checkAll("dbuf.c18", 1'b0, 1'b0, 1'b1, 1'b1);
        else
          checkAll("dbuf.c19", 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0);
      end
    end
`endif

    // Randomized phase against a per-cycle output slot queue
    applyStimulus(1'b1, 1'b0, '0);
    modelQ.delete();
    mReady = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 2) == 0);
      p = WIDTH'($urandom);
      if (r) begin
        modelQ.delete();
      end else if (s && mReady) begin
        for (int k = WIDTH - 1; k >= 0; k--) modelQ.push_back(slot_t'{ld: 1'b1, so: p[k], dn: 1'b0});
        modelQ.push_back(slot_t'{ld: 1'b0, so: 1'b0, dn: 1'b1});
      end
      applyStimulus(r, s, p);
      if (modelQ.size() > 0) cur = modelQ.pop_front();
      else cur = slot_t'{ld: 1'b0, so: 1'b0, dn: 1'b0};
`ifdef P2S_TX_DOUBLE_BUF_EN
      mReady = (modelQ.size() <= WIDTH);
`else
      mReady = (modelQ.size() == 0) && !cur.ld && !cur.dn;
`endif
      checkAll($sformatf("rand.c%0d", cyc), cur.ld, cur.so, cur.dn, mReady);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
